uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver: synchronises the serial `rx` line, detects start bits, samples each bit at mid-point using a 16× baud tick, and assembles a DATA_WIDTH-bit word. It sits directly upstream of the receive FIFO. Each good word produces a one-cycle `data_valid` write strobe alongside `data_out`, which feed the FIFO controller's write side. Framing, overrun and (optionally) parity errors are flagged as one-cycle pulses.

## Interface
- `DATA_WIDTH`, 8: bits per character, LSB first on the line.
- `OVERSAMPLE`, 16: `baud_tick` pulses per bit period; must be an even number ≥ 4.
- `clk` input 1: single system clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line; idles high.
- `baud_tick` input 1: single-cycle enable at OVERSAMPLE × baud rate, from the baud generator.
- `fifo_full` input 1: full flag of the downstream receive FIFO.
- `data_out` output DATA_WIDTH: received word; valid only while `data_valid` is high.
- `data_valid` output 1: one-cycle write strobe to the FIFO.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err` output 1: one-cycle pulse when a good word is dropped because `fifo_full` was high.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser whose flops reset to 1. All decisions use the synchronised value `rx_s`.
- Counters:
  - `tick_cnt` is log2(OVERSAMPLE) bits and advances only on cycles where `baud_tick` = 1.
  - `bit_cnt` counts from 0 to DATA_WIDTH−1.
- State machine:
  - IDLE: on a `baud_tick` cycle with `rx_s` = 0, go to START and set `tick_cnt` = 0.
  - START: on a tick with `tick_cnt` = OVERSAMPLE/2−1, check `rx_s`.
    - If 0: go to DATA and set `tick_cnt` = 0, `bit_cnt` = 0.
    - If 1: treat as a glitch and return to IDLE with no outputs.
  - DATA: on a tick with `tick_cnt` = OVERSAMPLE−1, shift `rx_s` into the MSB of the shift register (shift right) and reset `tick_cnt` to 0.
    - After bit DATA_WIDTH−1, go to PARITY (macro defined) or STOP.
  - PARITY: sample as in DATA, then go to STOP.
  - STOP: on a tick with `tick_cnt` = OVERSAMPLE−1, sample `rx_s` and return to IDLE.
    - `rx_s` = 1, `fifo_full` = 0 (and parity good, if enabled): `data_valid` = 1 and `data_out` = shift register.
    - `rx_s` = 1, `fifo_full` = 1: `overrun_err` = 1; no `data_valid`.
    - `rx_s` = 0: `frame_err` = 1; no `data_valid`, regardless of `fifo_full`.
- On return to IDLE a new start bit can be detected on the very next tick. This allows back-to-back frames with a stop bit of exactly one bit time.
- `data_out` holds its last value between strobes.

## Timing
- All outputs are registered. Reset values:
  - `data_out` = 0
  - `data_valid`, `frame_err`, `overrun_err`, `busy` = 0
  - state = IDLE, counters = 0, synchroniser = 1
- Synchroniser latency is 2 `clk` cycles from a `rx` edge to `rx_s`.
- Strobes: `data_valid`, `frame_err` and `overrun_err` are high for exactly the one cycle after the clock edge that samples the stop bit.
- `busy` rises in the cycle after IDLE→START and falls in the same cycle the strobe rises.
- Error priority in STOP: `frame_err` wins over `parity_err`, which wins over `overrun_err`. Only one error pulse fires per frame.
- Reset mid-frame: `rst` wins unconditionally. Any partial word is discarded and no strobe fires.
- `fifo_full` is sampled only at the stop-bit sampling edge.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state and `parity_err` output (1 bit, one-cycle pulse) are compiled in, with even parity.
  - `parity_err` fires when the XOR of the data bits and the parity bit is 1. In that case there is no `data_valid`.
  - Frame length is 1 + DATA_WIDTH + 1 + 1 bits.
- Not defined: no PARITY state and no `parity_err` port. Frame length is 1 + DATA_WIDTH + 1 bits.

## Structure
- Shared package `uart_pkg`:
  - receiver state encoding (IDLE, START, DATA, PARITY, STOP)
  - default OVERSAMPLE and DATA_WIDTH constants, shared with the transmitter and baud generator
- Sub-module `sync_2ff`: a 1-bit two-flop synchroniser with a reset value parameter (1 here), reusable by other async inputs.

## Test plan
Bench conditions for all scenarios: `baud_tick` every 4 `clk`, OVERSAMPLE = 16, macro off unless stated.
1. Frame 0xA5 (LSB first, stop = 1), `fifo_full` = 0 → exactly one `data_valid` pulse with `data_out` = 0xA5. No error pulses. `busy` is low afterwards.
2. Two back-to-back frames 0x00 then 0xFF with no idle gap → two `data_valid` pulses, 160 ticks apart, carrying 0x00 then 0xFF.
3. Frame 0x3C with stop bit driven 0 → `frame_err` pulse and no `data_valid`. A following good frame 0x12 is received correctly.
4. `rx` low for 4 ticks only (glitch) → return to IDLE. No strobes; `busy` pulses and then clears.
5. Frame 0x55 with `fifo_full` = 1 at the stop bit → `overrun_err` pulse, no `data_valid`. `rst` asserted at bit 4 of the next frame → all outputs 0, and a subsequent frame 0x81 is received correctly.
6. With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `data_valid`, `data_out` = 0x07. 0x07 with parity bit 0 → `parity_err` pulse and no `data_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants
// used by the receiver, transmitter and baud generator.
package uart_pkg;

   localparam int unsigned UART_DATA_WIDTH = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous inputs; both flops reset to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding the receive FIFO write side.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  baud_tick,
   input  logic                  fifo_full,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   logic rx_s;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   rx_state_e             state_q, state_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  valid_d, frame_d, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic                  par_q, par_d, parity_d;
`endif

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_out;
      valid_d   = 1'b0;
      frame_d   = 1'b0;
      overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      parity_d  = 1'b0;
`endif
      if (baud_tick) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  state_d = StStart;
                  tick_d  = '0;
               end
            end
            StStart: begin
               if (tick_q == TICK_HALF) begin
                  if (!rx_s) begin
                     state_d = StData;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            StData: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  par_d   = rx_s;
                  state_d = StStop;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
`endif
            StStop: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = StIdle;
                  // Exactly one outcome per frame: framing, then parity, then overrun.
                  if (!rx_s) begin
                     frame_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (^{shift_q, par_q}) begin
                     parity_d = 1'b1;
`endif
                  end else if (fifo_full) begin
                     overrun_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q       <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         data_out    <= data_d;
         data_valid  <= valid_d;
         frame_err   <= frame_d;
         overrun_err <= overrun_d;
         busy        <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
         par_q       <= par_d;
         parity_err  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames scored
// against a frame-level outcome model.
module tb_uart_rx;

   localparam int DW       = 8;
   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif
   localparam int FRAME_BITS = 1 + DW + (HAS_PAR ? 1 : 0) + 1;

   localparam int OUT_OK = 0;
   localparam int OUT_FE = 1;
   localparam int OUT_PE = 2;
   localparam int OUT_OV = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx = 1'b1;
   logic          baud_tick = 1'b0;
   logic          fifo_full = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid, frame_err, overrun_err, busy;
   logic          parity_err;

   int tests = 0;
   int fails = 0;

   uart_rx #(
      .DATA_WIDTH (DW),
      .OVERSAMPLE (OS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .baud_tick   (baud_tick),
      .fifo_full   (fifo_full),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .busy        (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );
`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   initial forever #5 clk = ~clk;

   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Event monitor: running totals, sampled mid-cycle.
   longint        cyc = 0;
   int            n_valid = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_busy = 0;
   logic [DW-1:0] got_q[$];
   longint        valid_t[$];
   logic          busy_at_valid = 1'b1;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (data_valid) begin
            n_valid <= n_valid + 1;
            got_q.push_back(data_out);
            valid_t.push_back(cyc);
            busy_at_valid <= busy;
         end
         if (frame_err)   n_fe   <= n_fe + 1;
         if (overrun_err) n_ov   <= n_ov + 1;
         if (parity_err)  n_pe   <= n_pe + 1;
         if (busy)        n_busy <= n_busy + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int outcome(input logic [DW-1:0] d, input logic stop, input logic par,
                                  input logic full);
      if (!stop) return OUT_FE;
      if (HAS_PAR && ((^d) != par)) return OUT_PE;
      if (full) return OUT_OV;
      return OUT_OK;
   endfunction

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par);
      drive_bit(1'b0);
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      if (HAS_PAR) drive_bit(par);
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic stop,
                            input logic full, input logic par);
      int vb, fb, ob, pb, exp;
      vb = n_valid; fb = n_fe; ob = n_ov; pb = n_pe;
      exp = outcome(d, stop, par, full);
      fifo_full = full;
      send_frame(d, stop, par);
      fifo_full = 1'b0;
      idle_bits(2);
      check({tag, ".valid"}, 64'(n_valid - vb), (exp == OUT_OK) ? 64'd1 : 64'd0);
      check({tag, ".frame"}, 64'(n_fe - fb), (exp == OUT_FE) ? 64'd1 : 64'd0);
      check({tag, ".overrun"}, 64'(n_ov - ob), (exp == OUT_OV) ? 64'd1 : 64'd0);
      check({tag, ".parity"}, 64'(n_pe - pb), (exp == OUT_PE) ? 64'd1 : 64'd0);
      if (exp == OUT_OK && got_q.size() > vb) check({tag, ".data"}, 64'(got_q[vb]), 64'(d));
      check({tag, ".busy_after"}, 64'(busy), 64'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".data_out"}, 64'(data_out), 64'd0);
      check({tag, ".strobes"}, 64'({data_valid, frame_err, overrun_err, parity_err}), 64'd0);
      check({tag, ".busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int vb, fb, ob, bb;
      logic [DW-1:0] d;
      logic stop, full, par;

      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      idle_bits(1);

      // 1: single good frame, busy must drop in the strobe cycle
      run_frame("t1", 8'hA5, 1'b1, 1'b0, ^8'hA5);
      check("t1.busy_at_strobe", 64'(busy_at_valid), 64'd0);

      // 2: back-to-back frames, no idle gap
      vb = n_valid;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, ^8'hFF);
      idle_bits(2);
      check("t2.count", 64'(n_valid - vb), 64'd2);
      if (got_q.size() >= vb + 2) begin
         check("t2.data0", 64'(got_q[vb]), 64'h00);
         check("t2.data1", 64'(got_q[vb+1]), 64'hFF);
         check("t2.spacing", 64'(valid_t[vb+1] - valid_t[vb]), 64'(FRAME_BITS * BIT_CLKS));
      end

      // 3: framing error then a good frame
      run_frame("t3a", 8'h3C, 1'b0, 1'b0, ^8'h3C);
      run_frame("t3b", 8'h12, 1'b1, 1'b0, ^8'h12);

      // 4: short glitch on the line
      vb = n_valid; fb = n_fe; ob = n_ov; bb = n_busy;
      rx = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      idle_bits(2);
      check("t4.strobes", 64'((n_valid - vb) + (n_fe - fb) + (n_ov - ob)), 64'd0);
      check("t4.busy_seen", 64'(n_busy > bb), 64'd1);
      check("t4.busy_after", 64'(busy), 64'd0);

      // 5: overrun, then reset in the middle of the next frame
      run_frame("t5a", 8'h55, 1'b1, 1'b1, ^8'h55);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("t5.rst");
      rst = 1'b0;
      vb = n_valid; fb = n_fe;
      idle_bits(2);
      check("t5.no_strobe", 64'((n_valid - vb) + (n_fe - fb)), 64'd0);
      run_frame("t5b", 8'h81, 1'b1, 1'b0, ^8'h81);

`ifdef UART_RX_PARITY_EN
      // 6: parity good and bad
      run_frame("t6a", 8'h07, 1'b1, 1'b0, 1'b1);
      run_frame("t6b", 8'h07, 1'b1, 1'b0, 1'b0);
`endif

      // Random frames scored by the outcome model
      for (int k = 0; k < 8; k++) begin
         d    = DW'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         full = ($urandom_range(0, 2) == 0);
         par  = (^d) ^ ($urandom_range(0, 3) == 0);
         run_frame($sformatf("rnd%0d", k), d, stop, full, par);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
